// File: rtl/apb_req_arb_if.sv
// apb_req_arb_if: requester-side and APB-side signals of apb_req_arb.
// The master modport is the arbiter's view, because it masters the APB bus.
// The slave modport is the view of the requesters and the register file.
interface apb_req_arb_if #(
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned DATA_W = 16
);
  logic              m0_req;
  logic              m0_write;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_done;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_err;

  logic              m1_req;
  logic              m1_write;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_done;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_err;

  logic [ADDR_W-1:0] req_paddr;
  logic              req_pwrite;
  logic              req_psel;
  logic              req_penable;
  logic [DATA_W-1:0] req_pwdata;
  logic              req_pready;
  logic [DATA_W-1:0] req_prdata;
  logic              req_pslverr;

  logic              arb_busy;
  logic              timeout_evt;

  modport master (
    input  m0_req, m0_write, m0_addr, m0_wdata,
    output m0_done, m0_rdata, m0_err,
    input  m1_req, m1_write, m1_addr, m1_wdata,
    output m1_done, m1_rdata, m1_err,
    output req_paddr, req_pwrite, req_psel, req_penable, req_pwdata,
    input  req_pready, req_prdata, req_pslverr,
    output arb_busy, timeout_evt
  );

  modport slave (
    output m0_req, m0_write, m0_addr, m0_wdata,
    input  m0_done, m0_rdata, m0_err,
    output m1_req, m1_write, m1_addr, m1_wdata,
    input  m1_done, m1_rdata, m1_err,
    input  req_paddr, req_pwrite, req_psel, req_penable, req_pwdata,
    output req_pready, req_prdata, req_pslverr,
    input  arb_busy, timeout_evt
  );
endinterface

// File: rtl/apb_req_arb.sv
// apb_req_arb: two-requester round-robin arbiter driving one APB request bus
// (clk_100m domain). It sequences SETUP/ACCESS for the granted port and
// returns read data and error to it. All outputs are registered.
// Optional ACCESS-phase abort is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arb #(
  parameter int unsigned ADDR_W      = 21,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input logic           clk_100m,
  input logic           rst_100m,
  apb_req_arb_if.master bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("apb_req_arb: TIMEOUT_CYC must be in 2..65535");
  end

  logic [1:0]        r_state;
  logic              r_ptr;
  logic              r_gnt;
  logic              r_busy;
  logic              r_psel;
  logic              r_penable;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_m0_done;
  logic              r_m1_done;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;
  logic              r_m0_err;
  logic              r_m1_err;

  logic              w_both;
  logic              w_any;
  logic              w_sel;
  logic              w_fin;
  logic              w_err;
  logic              w_rd_load;
  logic [DATA_W-1:0] w_rd;
  logic              w_tout;

`ifdef APB_ARB_TIMEOUT_EN
  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] r_tcnt;
  logic        r_tevt;
`endif

  // Arbitration: a lone requester wins; under contention the pointer decides.
  always_comb begin
    w_both = bus.m0_req & bus.m1_req;
    w_any  = bus.m0_req | bus.m1_req;
    w_sel  = w_both ? r_ptr : bus.m1_req;
  end

  // ACCESS completion: pready wins over an abort landing in the same cycle.
  always_comb begin
    w_fin     = 1'b0;
    w_err     = 1'b0;
    w_rd_load = 1'b0;
    w_rd      = '0;
    w_tout    = 1'b0;
    if (r_state == ST_ACCESS) begin
      if (bus.req_pready) begin
        w_fin     = 1'b1;
        w_err     = bus.req_pslverr;
        w_rd_load = ~r_pwrite;
        w_rd      = bus.req_prdata;
      end
`ifdef APB_ARB_TIMEOUT_EN
      else if (r_tcnt == LP_TO_LAST) begin
        w_fin     = 1'b1;
        w_err     = 1'b1;
        w_rd_load = 1'b1;
        w_rd      = '0;
        w_tout    = 1'b1;
      end
`endif
    end
  end

  // Main FSM, bus drive and per-port completion results.
  always_ff @(posedge clk_100m) begin
    if (rst_100m) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 1'b0;
      r_gnt      <= 1'b0;
      r_busy     <= 1'b0;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_paddr    <= '0;
      r_pwrite   <= 1'b0;
      r_pwdata   <= '0;
      r_m0_done  <= 1'b0;
      r_m1_done  <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_m0_err   <= 1'b0;
      r_m1_err   <= 1'b0;
    end else begin
      r_m0_done <= w_fin & ~r_gnt;
      r_m1_done <= w_fin & r_gnt;
      if (w_fin) begin
        if (r_gnt) begin
          r_m1_err <= w_err;
          if (w_rd_load) r_m1_rdata <= w_rd;
        end else begin
          r_m0_err <= w_err;
          if (w_rd_load) r_m0_rdata <= w_rd;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_sel;
            if (w_both) r_ptr <= ~w_sel;
            r_paddr  <= w_sel ? bus.m1_addr  : bus.m0_addr;
            r_pwrite <= w_sel ? bus.m1_write : bus.m0_write;
            r_pwdata <= w_sel ? bus.m1_wdata : bus.m0_wdata;
            r_psel   <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (w_fin) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= ST_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  // ACCESS wait counter (cleared while in SETUP) and abort event pulse.
  always_ff @(posedge clk_100m) begin
    if (rst_100m) begin
      r_tcnt <= '0;
      r_tevt <= 1'b0;
    end else begin
      r_tevt <= w_tout;
      if (r_state == ST_SETUP) r_tcnt <= '0;
      else if (r_state == ST_ACCESS && !bus.req_pready) r_tcnt <= r_tcnt + 16'd1;
    end
  end
  assign bus.timeout_evt = r_tevt;
`else
  assign bus.timeout_evt = 1'b0;
`endif

  assign bus.req_paddr   = r_paddr;
  assign bus.req_pwrite  = r_pwrite;
  assign bus.req_psel    = r_psel;
  assign bus.req_penable = r_penable;
  assign bus.req_pwdata  = r_pwdata;
  assign bus.m0_done     = r_m0_done;
  assign bus.m1_done     = r_m1_done;
  assign bus.m0_rdata    = r_m0_rdata;
  assign bus.m1_rdata    = r_m1_rdata;
  assign bus.m0_err      = r_m0_err;
  assign bus.m1_err      = r_m1_err;
  assign bus.arb_busy    = r_busy;
endmodule

// File: doc/apb_req_arb.md
Name: apb_req_arb

Overview:
- Two-requester arbiter that shares the single APB-style register request bus (21-bit address, 16-bit data) between the MDIO slave front-end (port 0) and a second master such as the I2C/test sequencer (port 1).
- Sequences the APB SETUP/ACCESS phases on behalf of the granted requester and returns read data and error.
- Uses round-robin fairness.
- Sits between the MDIO block, the second master and the register file, in the clk_100m domain.

Parameters:
- ADDR_W, 21, request address width.
- DATA_W, 16, read/write data width.
- TIMEOUT_CYC, 256, ACCESS-phase cycles before abort (only with the optional feature); legal range 2..65535.

Ports:
- clk_100m  input  1  block clock.
- rst_100m  input  1  synchronous active-high reset.
- m0_req  input  1  requester 0 transaction request; held until m0_done.
- m0_write  input  1  requester 0 write (1) / read (0).
- m0_addr  input  ADDR_W  requester 0 address.
- m0_wdata  input  DATA_W  requester 0 write data.
- m0_done  output  1  one-cycle completion pulse to requester 0.
- m0_rdata  output  DATA_W  requester 0 read data; valid with m0_done, held until next m0 completion.
- m0_err  output  1  requester 0 error; valid with m0_done.
- m1_req, m1_write, m1_addr, m1_wdata, m1_done, m1_rdata, m1_err: same as m0 for requester 1.
- req_paddr  output  ADDR_W  APB address.
- req_pwrite  output  1  APB write.
- req_psel  output  1  APB select.
- req_penable  output  1  APB enable.
- req_pwdata  output  DATA_W  APB write data.
- req_pready  input  1  APB ready.
- req_prdata  input  DATA_W  APB read data.
- req_pslverr  input  1  APB slave error.
- arb_busy  output  1  high whenever FSM is not IDLE.
- timeout_evt  output  1  one-cycle pulse on access abort.

Behaviour:
- Clock and reset: one clock, clk_100m; reset rst_100m is synchronous, active-high.
- Registered outputs: all outputs are registered. On reset, every output is 0, FSM = IDLE, round-robin pointer = 0 (port 0 preferred).
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - No req: stay.
  - One req: grant it.
  - Both req: grant the port the pointer prefers; pointer then flips to the other port.
  - On grant, latch addr/write/wdata of the granted port into req_p* and go to SETUP. In the next cycle psel=1, penable=0.
- SETUP: unconditional next state ACCESS (psel=1, penable=1).
- ACCESS:
  - Hold until req_pready=1.
  - On pready, capture req_prdata (reads only; writes leave rdata unchanged) and req_pslverr into the granted port's rdata/err.
  - Drive psel=0, penable=0, pulse granted mX_done for exactly one cycle; go to DONE.
- DONE: one cycle, arb_busy still 1, no grant. This gives the requester one cycle to drop req. Then go to IDLE.
- Latency:
  - m0_req rising in IDLE at cycle N: psel=1 at N+1, penable=1 at N+2.
  - With pready=1 at N+2: m0_done=1 at N+3, IDLE at N+4. A new grant is possible at N+4, so psel can rise at N+5.
- Request-side rules:
  - A requester still asserting req in the IDLE cycle after DONE is treated as a new transaction.
  - Requester fields are sampled only in the grant cycle; changes afterwards are ignored.
  - Deassertion of a granted req mid-transaction is ignored; the transaction completes and done still pulses.
- Outputs not driven: m*_done and timeout_evt are never asserted for a non-granted port.
- Fairness: under continuous requests from both ports, grants alternate 0,1,0,1…
- Reset mid-transaction: psel/penable drop to 0 in the cycle after reset is sampled. No done pulse; pointer returns to 0.
- Parked bus: req_paddr/req_pwrite/req_pwdata hold their last values outside transactions.

Optional Feature:
- Macro APB_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle without pready.
  - When it reaches TIMEOUT_CYC-1 with pready still 0, the access aborts: psel/penable go to 0, granted mX_done=1 with mX_err=1, mX_rdata=0, timeout_evt=1 for one cycle; go to DONE.
  - pready arriving in the abort cycle takes priority: normal completion, no timeout.
- When undefined: no counter; ACCESS waits indefinitely; timeout_evt is tied to 0.

Test Plan:
- m0 write addr=21'h1_0004, wdata=16'hA5A5, pready at first ACCESS cycle -> paddr=21'h1_0004, pwrite=1, pwdata=16'hA5A5; psel at N+1, penable at N+2, m0_done at N+3, m0_err=0.
- m1 read addr=21'h0_0010, pready after 3 wait cycles, prdata=16'h1234 -> m1_done one cycle after pready, m1_rdata=16'h1234, m0_done stays 0.
- m0_req and m1_req held high continuously, pready=1 -> granted sequence 0,1,0,1; each grant spaced 4 cycles.
- m0 read, pready=1 with pslverr=1 -> m0_done=1, m0_err=1, m0_rdata=prdata.
- APB_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=8, pready held 0 -> abort after 8 ACCESS cycles; m0_done=1, m0_err=1, m0_rdata=0, timeout_evt=1 for one cycle, bus idle afterwards.
- rst_100m asserted during ACCESS -> next cycle psel=0, penable=0, arb_busy=0, no done pulse; a subsequent m1_req alone is granted normally.
